// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: command and response handshake bundle for the ALU command issuer
interface alu_cmd_issuer_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [1:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_result;
  logic             rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_mismatch;
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_tag, rsp_mismatch
  );
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_tag, rsp_mismatch
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: issues commands to a registered 4-bit ALU, tracks them through its latency
// and queues tagged results checked against a golden model
module alu_cmd_issuer #(
  parameter int TAG_W       = 4,
  parameter int ALU_LATENCY = 2,
  parameter int RSP_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_issuer_if.slave  bus,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_sel,
  input  logic [3:0]       alu_result,
  input  logic             alu_zero,
  output logic [7:0]       mismatch_cnt
);
  localparam int S  = ALU_LATENCY + 1;
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RSP_DEPTH);
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    count;
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [S-1:0]     pv;
  logic [TAG_W-1:0] ptag [S];
  logic [3:0]       pexp [S];
  logic [3:0]       m_res [RSP_DEPTH];
  logic             m_zero [RSP_DEPTH];
  logic [TAG_W-1:0] m_tag [RSP_DEPTH];
  logic             m_mis [RSP_DEPTH];
  logic             acc;
  logic             pop;
  logic             wr;
  logic             mis;
  logic [3:0]       gold;
  // Ready only depends on registered occupancy, so a write can never hit a full FIFO
  assign bus.cmd_ready    = rst_n && (outstanding < FULL);
  assign acc              = bus.cmd_valid && bus.cmd_ready;
  assign bus.rsp_valid    = count != '0;
  assign pop              = bus.rsp_valid && bus.rsp_ready;
  assign wr               = pv[S-1];
  assign mis              = (alu_result != pexp[S-1]) || (alu_zero != (pexp[S-1] == 4'h0));
  assign bus.rsp_result   = m_res[rp];
  assign bus.rsp_zero     = m_zero[rp];
  assign bus.rsp_tag      = m_tag[rp];
  assign bus.rsp_mismatch = m_mis[rp];
  always_comb begin
    gold = bus.cmd_op == 2'd0 ? bus.cmd_a + bus.cmd_b :
           bus.cmd_op == 2'd1 ? bus.cmd_a + ~bus.cmd_b + 4'd1 :
           bus.cmd_op == 2'd2 ? bus.cmd_a & bus.cmd_b : bus.cmd_a | bus.cmd_b;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      outstanding <= '0;
      pv          <= '0;
      for (int k = 0; k < S; k++) begin
        ptag[k] <= '0;
        pexp[k] <= '0;
      end
    end else begin
      if (acc) begin
        alu_a   <= bus.cmd_a;
        alu_b   <= bus.cmd_b;
        alu_sel <= bus.cmd_op;
      end
      outstanding <= outstanding + CW'(acc) - CW'(pop);
      pv          <= {pv[S-2:0], acc};
      ptag[0]     <= bus.cmd_tag;
      pexp[0]     <= gold;
      for (int k = 1; k < S; k++) begin
        ptag[k] <= ptag[k-1];
        pexp[k] <= pexp[k-1];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      mismatch_cnt <= '0;
      for (int k = 0; k < RSP_DEPTH; k++) begin
        m_res[k]  <= '0;
        m_zero[k] <= 1'b0;
        m_tag[k]  <= '0;
        m_mis[k]  <= 1'b0;
      end
    end else begin
      if (wr) begin
        m_res[wp]  <= alu_result;
        m_zero[wp] <= alu_zero;
        m_tag[wp]  <= ptag[S-1];
        m_mis[wp]  <= mis;
        wp         <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(wr) - CW'(pop);
      if (wr && mis && mismatch_cnt != 8'hff) mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed vectors, backpressure/reset corner cases and random traffic
// against a queue-based reference model, with a simple 2-stage ALU attached
module tb_alu_cmd_issuer;
  logic       clk;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_sel;
  logic       alu_zero;
  logic [7:0] mismatch_cnt;
  logic [3:0] r1, r2;
  bit         force_mode;
  int         total = 0;
  int         bad = 0;
  int         n_acc = 0;
  int         mcnt = 0;
  typedef struct {
    logic [3:0] res;
    logic       zero;
    logic [3:0] tag;
    logic       mis;
  } exp_t;
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] tag;
    logic [3:0] res;
    logic       zero;
  } vec_t;
  exp_t       q[$];
  exp_t       me;
  logic [3:0] popped[$];
  vec_t       vt[7];

  alu_cmd_issuer_if #(.TAG_W(4)) bus ();

  alu_cmd_issuer #(.TAG_W(4), .ALU_LATENCY(2), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero), .mismatch_cnt(mismatch_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Registered ALU: inputs latched by the issuer at E0, result valid after E0+2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1 <= '0;
      r2 <= '0;
    end else begin
      r1 <= alu_sel == 2'd0 ? alu_a + alu_b : alu_sel == 2'd1 ? alu_a - alu_b :
            alu_sel == 2'd2 ? alu_a & alu_b : alu_a | alu_b;
      r2 <= r1;
    end
  end
  assign alu_result = force_mode ? 4'h0 : r2;
  assign alu_zero   = (r2 == 4'h0);

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int op, input int tag, input bit frc);
    int r;
    r = op == 0 ? (a + b) % 16 : op == 1 ? (a - b + 16) % 16 : op == 2 ? (a & b) : (a | b);
    model.res  = frc ? 4'h0 : 4'(r);
    model.zero = (r == 0);
    model.tag  = 4'(tag);
    model.mis  = frc && (r != 0);
  endfunction

  // Handshakes are observed at the falling edge and take effect at the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop tag=%0d", bus.rsp_tag);
        end else begin
          me = q.pop_front();
          chk("rsp_result", bus.rsp_result, me.res);
          chk("rsp_zero", bus.rsp_zero, me.zero);
          chk("rsp_tag", bus.rsp_tag, me.tag);
          chk("rsp_mismatch", bus.rsp_mismatch, me.mis);
          popped.push_back(bus.rsp_tag);
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        me = model(bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag, force_mode);
        q.push_back(me);
        n_acc++;
        if (me.mis && mcnt < 255) mcnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, input logic [3:0] tag);
    bus.cmd_valid = 1;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    bus.cmd_tag = tag;
    step();
    bus.cmd_valid = 0;
  endtask

  task automatic drain();
    bus.cmd_valid = 0;
    bus.rsp_ready = 1;
    for (int i = 0; i < 200 && (q.size() != 0 || bus.rsp_valid); i++) step();
    chk("drain_left", q.size(), 0);
    chk("drain_valid", bus.rsp_valid, 0);
    bus.rsp_ready = 0;
  endtask

  initial begin
    int cyc;
    int acc;
    int a0;
    vt[0] = '{4'h3, 4'h4, 2'd0, 4'h1, 4'h7, 1'b0};
    vt[1] = '{4'h5, 4'h5, 2'd1, 4'h2, 4'h0, 1'b1};
    vt[2] = '{4'h2, 4'h5, 2'd1, 4'h3, 4'hd, 1'b0};
    vt[3] = '{4'hc, 4'h3, 2'd2, 4'h4, 4'h0, 1'b1};
    vt[4] = '{4'ha, 4'h5, 2'd3, 4'h5, 4'hf, 1'b0};
    vt[5] = '{4'hf, 4'h1, 2'd0, 4'h6, 4'h0, 1'b1};
    vt[6] = '{4'h0, 4'h1, 2'd1, 4'h7, 4'hf, 1'b0};
    rst_n = 0;
    force_mode = 0;
    bus.cmd_valid = 0;
    bus.cmd_a = 0;
    bus.cmd_b = 0;
    bus.cmd_op = 0;
    bus.cmd_tag = 0;
    bus.rsp_ready = 0;
    repeat (2) step();
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_tag", bus.rsp_tag, 0);
    chk("rst_mcnt", mismatch_cnt, 0);
    rst_n = 1;
    step();
    chk("ready_after_rst", bus.cmd_ready, 1);

    for (int i = 0; i < 7; i++) begin
      send_one(vt[i].a, vt[i].b, vt[i].op, vt[i].tag);
      cyc = 0;
      while (!bus.rsp_valid && cyc < 20) begin
        step();
        cyc++;
      end
      if (i == 0) chk("latency", cyc, 3);
      chk("vec_valid", bus.rsp_valid, 1);
      chk("vec_result", bus.rsp_result, vt[i].res);
      chk("vec_zero", bus.rsp_zero, vt[i].zero);
      chk("vec_tag", bus.rsp_tag, vt[i].tag);
      chk("vec_mismatch", bus.rsp_mismatch, 0);
      bus.rsp_ready = 1;
      step();
      bus.rsp_ready = 0;
    end
    chk("vec_empty", bus.rsp_valid, 0);

    popped.delete();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid = 1;
      bus.cmd_tag = 4'(acc);
      bus.cmd_a = 4'(acc);
      bus.cmd_b = 4'd1;
      bus.cmd_op = 2'd0;
      if (bus.cmd_ready) acc++;
      step();
    end
    bus.cmd_valid = 0;
    chk("bp_accepted", acc, 4);
    chk("bp_ready_low", bus.cmd_ready, 0);
    chk("bp_head_stable", bus.rsp_tag, 0);
    bus.rsp_ready = 1;
    for (int i = 0; i < 40 && acc < 6; i++) begin
      bus.cmd_valid = 1;
      bus.cmd_tag = 4'(acc);
      bus.cmd_a = 4'(acc);
      if (bus.cmd_ready) acc++;
      step();
    end
    drain();
    chk("bp_popped_n", popped.size(), 6);
    for (int i = 0; i < popped.size(); i++) chk("bp_order", popped[i], i);

    for (int i = 0; i < 20 && bus.cmd_ready; i++) begin
      bus.cmd_valid = 1;
      bus.cmd_a = 4'(i);
      bus.cmd_b = 4'd3;
      bus.cmd_op = 2'd3;
      bus.cmd_tag = 4'(i);
      step();
    end
    repeat (4) step();
    chk("full_ready", bus.cmd_ready, 0);
    a0 = n_acc;
    bus.rsp_ready = 1;
    step();
    bus.rsp_ready = 0;
    chk("full_no_acc_on_pop", n_acc, a0);
    chk("full_ready_after_pop", bus.cmd_ready, 1);
    step();
    chk("full_acc_next", n_acc, a0 + 1);
    chk("full_ready_again", bus.cmd_ready, 0);
    drain();

    force_mode = 1;
    send_one(4'h1, 4'h1, 2'd0, 4'h9);
    drain();
    chk("force_mcnt1", mismatch_cnt, 1);
    a0 = n_acc;
    bus.rsp_ready = 1;
    bus.cmd_a = 4'h1;
    bus.cmd_b = 4'h1;
    bus.cmd_op = 2'd0;
    for (int i = 0; i < 3000 && n_acc < a0 + 300; i++) begin
      bus.cmd_valid = (n_acc + (bus.cmd_ready ? 1 : 0)) <= a0 + 300;
      bus.cmd_tag = 4'(i);
      step();
    end
    drain();
    force_mode = 0;
    chk("force_accepts", n_acc, a0 + 300);
    chk("mcnt_sat", mismatch_cnt, 255);
    chk("mcnt_model", mismatch_cnt, mcnt);

    for (int i = 0; i < 3; i++) send_one(4'(i), 4'h2, 2'd0, 4'(i));
    repeat (5) step();
    chk("pre_rst_valid", bus.rsp_valid, 1);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_valid", bus.rsp_valid, 0);
    chk("async_rst_ready", bus.cmd_ready, 0);
    chk("async_rst_mcnt", mismatch_cnt, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1;
    step();
    chk("post_rst_ready", bus.cmd_ready, 1);
    chk("post_rst_alu_a", alu_a, 0);
    bus.rsp_ready = 1;
    cyc = 0;
    repeat (8) begin
      step();
      if (bus.rsp_valid) cyc++;
    end
    bus.rsp_ready = 0;
    chk("no_stale_rsp", cyc, 0);

    for (int i = 0; i < 600; i++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_a = 4'($urandom);
      bus.cmd_b = 4'($urandom);
      bus.cmd_op = 2'($urandom);
      bus.cmd_tag = 4'($urandom);
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    drain();
    chk("rand_mcnt", mismatch_cnt, mcnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
